// File: rtl/pe_m_horner.sv
// pe_m_horner: RAVEN PE, GEMM systolic MAC step or UNO Horner chain folded into one PE.
// Optional feature macro PE_ACC_SAT_EN: saturating accumulator add (default: two's-complement wrap).
module pe_m_horner #(
    parameter int INT_BW = 7,
    parameter int FRA_BW = 8,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_i,
    input  logic              in_valid_i,
    input  logic [MUL_BW-1:0] x_i,
    input  logic [MUL_BW-1:0] wc_i,
    input  logic [ACC_BW-1:0] o_i,
    input  logic [ACC_BW-1:0] mac_i,
    input  logic              coef_we_i,
    input  logic [AW-1:0]     coef_addr_i,
    input  logic [AW:0]       nterms_i,
    input  logic              start_i,
    output logic              ready_o,
    output logic [MUL_BW-1:0] x_o,
    output logic [MUL_BW-1:0] wc_o,
    output logic [ACC_BW-1:0] o_o,
    output logic              valid_o,
    output logic              done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // largest accumulator value whose operand-format view is representable
    localparam logic signed [ACC_BW-1:0] TM_HI = ACC_BW'((64'sd1 <<< (INT_BW + 2*FRA_BW)) - 64'sd1);

    state_t            state_q, state_d;
    logic [AW:0]       k_q, k_d;
    logic [MUL_BW-1:0] v_q, v_d;
    logic [ACC_BW-1:0] acc_q, acc_d;
    logic [ACC_BW-1:0] o_q, o_d;
    logic              valid_q, valid_d;
    logic [MUL_BW-1:0] x_q, wc_q;
    logic [MUL_BW-1:0] coef_q [DEPTH];
    logic [AW-1:0]     ra;
    logic              idle;

    // signed product plus addend at ACC_BW+1, then saturate or wrap
    function automatic logic [ACC_BW-1:0] mac_f(input logic signed [MUL_BW-1:0] a,
                                                 input logic signed [MUL_BW-1:0] b,
                                                 input logic signed [ACC_BW-1:0] c);
        logic signed [2*MUL_BW-1:0] p;
        logic signed [ACC_BW:0]     s;
        p = a * b;
        s = (ACC_BW+1)'(p) + (ACC_BW+1)'(c);
`ifdef PE_ACC_SAT_EN
        if (s[ACC_BW] != s[ACC_BW-1]) return {s[ACC_BW], {(ACC_BW-1){~s[ACC_BW]}}};
`endif
        return s[ACC_BW-1:0];
    endfunction

    // accumulator back to operand format, clamping out-of-range values
    function automatic logic [MUL_BW-1:0] to_mul(input logic signed [ACC_BW-1:0] a);
        return a > TM_HI ? {1'b0, {(MUL_BW-1){1'b1}}} :
               a < ~TM_HI ? {1'b1, {(MUL_BW-1){1'b0}}} : a[INT_BW+2*FRA_BW:FRA_BW];
    endfunction

    assign idle    = state_q == IDLE;
    assign ra      = AW'(k_q - 1'b1);
    assign ready_o = idle;
    assign done_o  = state_q == DONE;
    assign o_o     = o_q;
    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign wc_o    = wc_q;

    // next state: GEMM step or UNO launch in IDLE, one Horner step per RUN cycle
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        v_d     = v_q;
        acc_d   = acc_q;
        o_d     = o_q;
        valid_d = 1'b0;
        if (idle) begin
            if (mode_i == 2'b00 && in_valid_i) begin
                o_d     = mac_f(x_i, wc_i, o_i);
                valid_d = 1'b1;
            end
            if (start_i && mode_i != 2'b00) begin
                v_d     = x_i;
                acc_d   = mac_i;
                k_d     = nterms_i > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : nterms_i;
                state_d = k_d == '0 ? DONE : RUN;
            end
        end else if (state_q == RUN) begin
            acc_d   = mac_f(to_mul(acc_q), v_q, ACC_BW'($signed(coef_q[ra])) <<< FRA_BW);
            k_d     = k_q - 1'b1;
            state_d = k_q == 1 ? DONE : RUN;
        end else begin
            state_d = IDLE;
        end
        if (state_d == DONE && state_q != DONE) begin
            o_d     = acc_d;
            valid_d = 1'b1;
        end
    end

    // FSM, UNO operands and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            v_q     <= '0;
            acc_q   <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
            x_q     <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            x_q     <= x_i;
            wc_q    <= wc_i;
        end
    end

    // coefficient file, writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) coef_q <= '{default: '0};
        else if (idle && coef_we_i) coef_q[coef_addr_i] <= wc_i;
    end
endmodule
